// File: rtl/patch_pkg.sv
// Shared constants and FSM encoding for patch loading.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the config-bus address map for the patch slot (CAM staging, offset RAM,
// content RAM, CAM index trigger), the RAM geometry, and the loader state enum.
package patch_pkg;

    localparam logic [15:0] CAM_ADDR_LO  = 16'h7000;
    localparam logic [15:0] CAM_ADDR_HI  = 16'h7001;
    localparam logic [15:0] CAM_MASK_LO  = 16'h7002;
    localparam logic [15:0] CAM_MASK_HI  = 16'h7003;
    localparam logic [15:0] CAM_INDEX    = 16'h7004;
    localparam logic [15:0] OFFSET_BASE  = 16'h7800;
    localparam logic [15:0] CONTENT_BASE = 16'h8000;

    localparam int CONTENT_AW = 13;
    localparam int INDEX_W    = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_PTR  = 3'd2,
        ST_DATA = 3'd3,
        ST_TRIG = 3'd4,
        ST_GAP  = 3'd5
    } state_t;

endpackage

// File: rtl/patch_loader.sv
// Turns a patch descriptor stream into the config-bus writes for one patch slot.
// Latency: each write appears one cycle after its accept edge (registered outputs).
// Backpressure: in_ready drops in TRIG/GAP and whenever host_strobe is high.
//
// Ports:
//   mclk, reset                   clock, async active-high reset
//   in_data/in_valid/in_ready     descriptor word stream (valid/ready)
//   host_addr/host_data/host_strobe  direct host config write, always wins
//   config_addr/data/strobe       merged config bus to patch_store
//   busy, done, loaded_count      status: not idle, trigger pulse, descriptors loaded
import patch_pkg::*;

module patch_loader #(
    parameter int CAM_GAP = 16,
    parameter int CNT_W   = 8
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      host_addr,
    input  logic [15:0]      host_data,
    input  logic             host_strobe,
    output logic [15:0]      config_addr,
    output logic [15:0]      config_data,
    output logic             config_strobe,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] loaded_count
);

    // +2 keeps the counter at least one bit wide for any CAM_GAP >= 0.
    localparam int GAP_W = $clog2(CAM_GAP + 2);

    state_t                  state_q, state_d;
    logic [2:0]              hdr_cnt_q, hdr_cnt_d;
    logic [INDEX_W-1:0]      index_q, index_d;
    logic [7:0]              n_q, n_d;
    logic [CONTENT_AW-1:0]   ptr_q, ptr_d;
    logic [GAP_W-1:0]        gap_q, gap_d;

    logic                    accept;
    logic                    wr_vld;
    logic [15:0]             wr_addr;
    logic [15:0]             wr_data;
    logic                    trig_fire;

    assign in_ready = ((state_q == ST_IDLE) || (state_q == ST_HDR) ||
                       (state_q == ST_PTR)  || (state_q == ST_DATA)) && !host_strobe;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != ST_IDLE);

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            hdr_cnt_q <= '0;
            index_q   <= '0;
            n_q       <= '0;
            ptr_q     <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            index_q   <= index_d;
            n_q       <= n_d;
            ptr_q     <= ptr_d;
            gap_q     <= gap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        index_d   = index_q;
        n_d       = n_q;
        ptr_d     = ptr_q;
        gap_d     = gap_q;
        wr_vld    = 1'b0;
        wr_addr   = 16'h0000;
        wr_data   = 16'h0000;
        trig_fire = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    index_d   = in_data[INDEX_W-1:0];
                    n_d       = in_data[15:8];
                    hdr_cnt_d = 3'd0;
                    state_d   = ST_HDR;
                end
            end
            // hdr_cnt 0..3 are the CAM staging words, 4 is the offset word.
            ST_HDR: begin
                if (accept) begin
                    wr_vld  = 1'b1;
                    wr_data = in_data;
                    if (hdr_cnt_q == 3'd4) begin
                        wr_addr = OFFSET_BASE | {{(16-INDEX_W){1'b0}}, index_q};
                        state_d = ST_PTR;
                    end else begin
                        wr_addr   = CAM_ADDR_LO + {13'd0, hdr_cnt_q};
                        hdr_cnt_d = hdr_cnt_q + 3'd1;
                    end
                end
            end
            ST_PTR: begin
                if (accept) begin
                    ptr_d   = in_data[CONTENT_AW-1:0];
                    state_d = (n_q == 8'd0) ? ST_TRIG : ST_DATA;
                end
            end
            // ptr is CONTENT_AW bits wide so the increment wraps 0x1FFF -> 0x0000.
            ST_DATA: begin
                if (accept) begin
                    wr_vld  = 1'b1;
                    wr_addr = CONTENT_BASE | {{(16-CONTENT_AW){1'b0}}, ptr_q};
                    wr_data = in_data;
                    ptr_d   = ptr_q + CONTENT_AW'(1);
                    n_d     = n_q - 8'd1;
                    if (n_q == 8'd1) begin
                        state_d = ST_TRIG;
                    end
                end
            end
            // A host write occupies the bus this cycle, so the trigger waits.
            ST_TRIG: begin
                if (!host_strobe) begin
                    wr_vld    = 1'b1;
                    wr_addr   = CAM_INDEX;
                    wr_data   = {{(16-INDEX_W){1'b0}}, index_q};
                    trig_fire = 1'b1;
                    gap_d     = GAP_W'(CAM_GAP - 1);
                    state_d   = (CAM_GAP == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Config bus register: host write has priority; loader writes only happen
    // when host_strobe is low, so at most one write lands per cycle.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            config_addr   <= 16'h0000;
            config_data   <= 16'h0000;
            config_strobe <= 1'b0;
            done          <= 1'b0;
            loaded_count  <= '0;
        end else begin
            config_strobe <= 1'b0;
            done          <= 1'b0;
            if (host_strobe) begin
                config_addr   <= host_addr;
                config_data   <= host_data;
                config_strobe <= 1'b1;
            end else if (wr_vld) begin
                config_addr   <= wr_addr;
                config_data   <= wr_data;
                config_strobe <= 1'b1;
            end
            if (trig_fire) begin
                done         <= 1'b1;
                loaded_count <= loaded_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_patch_loader.sv
// Directed bench for patch_loader: descriptor loads, pointer wrap, N=0,
// host collision, reset mid-descriptor and back-to-back gap timing.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_patch_loader;

    logic        mclk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_data = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] host_addr = 16'h0000;
    logic [15:0] host_data = 16'h0000;
    logic        host_strobe = 1'b0;
    logic [15:0] config_addr;
    logic [15:0] config_data;
    logic        config_strobe;
    logic        busy;
    logic        done;
    logic [7:0]  loaded_count;

    patch_loader #(.CAM_GAP(16), .CNT_W(8)) dut (
        .mclk          (mclk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .host_addr     (host_addr),
        .host_data     (host_data),
        .host_strobe   (host_strobe),
        .config_addr   (config_addr),
        .config_data   (config_data),
        .config_strobe (config_strobe),
        .busy          (busy),
        .done          (done),
        .loaded_count  (loaded_count)
    );

    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    // Write log captured from the config bus.
    logic [15:0] log_a[$];
    logic [15:0] log_d[$];
    int          log_c[$];
    int          done_cnt = 0;
    logic [15:0] exp_a[$];
    logic [15:0] exp_d[$];

    always @(negedge mclk) begin
        if (!reset) begin
            if (config_strobe) begin
                log_a.push_back(config_addr);
                log_d.push_back(config_data);
                log_c.push_back(cyc);
            end
            if (done) done_cnt++;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic clear_all();
        log_a.delete();
        log_d.delete();
        log_c.delete();
        exp_a.delete();
        exp_d.delete();
        done_cnt = 0;
    endtask

    task automatic expw(input logic [15:0] a, input logic [15:0] d);
        exp_a.push_back(a);
        exp_d.push_back(d);
    endtask

    task automatic compare_log(input string tag);
        chk({tag, "_nwrites"}, log_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < log_a.size(); i++) begin
            chk($sformatf("%s_w%0d_addr", tag, i), {16'h0, log_a[i]}, {16'h0, exp_a[i]});
            chk($sformatf("%s_w%0d_data", tag, i), {16'h0, log_d[i]}, {16'h0, exp_d[i]});
        end
    endtask

    // Offer one word and hold it until accepted; bounded wait.
    task automatic send(input logic [15:0] w);
        int g;
        g = 0;
        in_data  = w;
        in_valid = 1'b1;
        #1;
        while (!in_ready && g < 200) begin
            @(negedge mclk);
            #1;
            g++;
        end
        if (g >= 200) chk("send_timeout", 32'd0, 32'd1);
        @(negedge mclk);
        in_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] w0, input logic [15:0] a_lo, input logic [15:0] a_hi,
                            input logic [15:0] m_lo, input logic [15:0] m_hi,
                            input logic [15:0] off, input logic [15:0] p);
        send(w0); send(a_lo); send(a_hi); send(m_lo); send(m_hi); send(off); send(p);
    endtask

    task automatic wait_writes(input int n);
        int g;
        g = 0;
        while (log_a.size() < n && g < 200) begin
            @(negedge mclk);
            g++;
        end
        #1;
    endtask

    int n_low;
    int g;
    int diff;

    initial begin
        // ---- reset state ----
        repeat (3) @(negedge mclk);
        #1;
        chk("rst_addr",   {16'h0, config_addr}, 32'h0);
        chk("rst_data",   {16'h0, config_data}, 32'h0);
        chk("rst_strobe", {31'h0, config_strobe}, 32'h0);
        chk("rst_done",   {31'h0, done}, 32'h0);
        chk("rst_count",  {24'h0, loaded_count}, 32'h0);
        chk("rst_busy",   {31'h0, busy}, 32'h0);
        @(negedge mclk);
        reset = 1'b0;
        #1;
        chk("idle_ready", {31'h0, in_ready}, 32'h1);

        // ---- test 1: basic load ----
        clear_all();
        send_hdr(16'h0205, 16'h3456, 16'h0012, 16'hFF00, 16'h007F, 16'h0100, 16'h0200);
        send(16'hAAAA);
        send(16'h5555);
        g = 0;
        do begin
            @(negedge mclk);
            #1;
            g++;
        end while (!done && g < 50);
        chk("t1_done_seen", {31'h0, done}, 32'h1);
        n_low = 0;
        while (!in_ready && n_low < 100) begin
            n_low++;
            @(negedge mclk);
            #1;
        end
        chk("t1_ready_low", n_low, 32'd16);
        expw(16'h7000, 16'h3456); expw(16'h7001, 16'h0012);
        expw(16'h7002, 16'hFF00); expw(16'h7003, 16'h007F);
        expw(16'h7805, 16'h0100); expw(16'h8200, 16'hAAAA);
        expw(16'h8201, 16'h5555); expw(16'h7004, 16'h0005);
        compare_log("t1");
        chk("t1_done_cnt", done_cnt, 32'd1);
        chk("t1_count", {24'h0, loaded_count}, 32'd1);
        chk("t1_busy", {31'h0, busy}, 32'h0);

        // ---- test 2: pointer wrap ----
        clear_all();
        send_hdr(16'h0301, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h1FFF);
        send(16'h0001);
        send(16'h0002);
        send(16'h0003);
        wait_writes(9);
        expw(16'h7000, 16'h0001); expw(16'h7001, 16'h0002);
        expw(16'h7002, 16'h0003); expw(16'h7003, 16'h0004);
        expw(16'h7801, 16'h0005); expw(16'h9FFF, 16'h0001);
        expw(16'h8000, 16'h0002); expw(16'h8001, 16'h0003);
        expw(16'h7004, 16'h0001);
        compare_log("t2");
        chk("t2_count", {24'h0, loaded_count}, 32'd2);

        // ---- test 3: N = 0 ----
        clear_all();
        send_hdr(16'h003F, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h0000);
        wait_writes(6);
        expw(16'h7000, 16'h1111); expw(16'h7001, 16'h2222);
        expw(16'h7002, 16'h3333); expw(16'h7003, 16'h4444);
        expw(16'h783F, 16'h5555); expw(16'h7004, 16'h003F);
        compare_log("t3");
        diff = (log_c.size() >= 6) ? (log_c[5] - log_c[4]) : -1;
        chk("t3_trig_timing", diff, 32'd2);
        chk("t3_count", {24'h0, loaded_count}, 32'd3);

        // ---- test 4: host collision on a data word ----
        clear_all();
        send_hdr(16'h0202, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4, 16'h00A5, 16'h0010);
        send(16'hBEEF);
        in_data     = 16'hCAFE;
        in_valid    = 1'b1;
        host_addr   = 16'h7004;
        host_data   = 16'h0001;
        host_strobe = 1'b1;
        #1;
        chk("t4_ready_during_host", {31'h0, in_ready}, 32'h0);
        @(negedge mclk);
        host_strobe = 1'b0;
        #1;
        chk("t4_ready_after_host", {31'h0, in_ready}, 32'h1);
        @(negedge mclk);
        in_valid = 1'b0;
        wait_writes(10);
        repeat (3) @(negedge mclk);
        #1;
        expw(16'h7000, 16'h00A1); expw(16'h7001, 16'h00A2);
        expw(16'h7002, 16'h00A3); expw(16'h7003, 16'h00A4);
        expw(16'h7802, 16'h00A5); expw(16'h8010, 16'hBEEF);
        expw(16'h7004, 16'h0001); expw(16'h8011, 16'hCAFE);
        expw(16'h7004, 16'h0002);
        compare_log("t4");
        diff = (log_c.size() >= 8) ? (log_c[7] - log_c[6]) : -1;
        chk("t4_host_then_loader", diff, 32'd1);
        chk("t4_done_cnt", done_cnt, 32'd1);
        chk("t4_count", {24'h0, loaded_count}, 32'd4);

        // ---- test 5: reset mid-DATA ----
        send_hdr(16'h0403, 16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04, 16'h0B05, 16'h0050);
        send(16'h1234);
        @(negedge mclk);
        #1;
        clear_all();
        reset = 1'b1;
        #1;
        chk("t5_addr",   {16'h0, config_addr}, 32'h0);
        chk("t5_data",   {16'h0, config_data}, 32'h0);
        chk("t5_strobe", {31'h0, config_strobe}, 32'h0);
        chk("t5_count",  {24'h0, loaded_count}, 32'h0);
        chk("t5_busy",   {31'h0, busy}, 32'h0);
        @(negedge mclk);
        reset = 1'b0;
        send_hdr(16'h0107, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 16'h0E0E, 16'h0100);
        send(16'h7777);
        wait_writes(7);
        repeat (3) @(negedge mclk);
        #1;
        expw(16'h7000, 16'h0A0A); expw(16'h7001, 16'h0B0B);
        expw(16'h7002, 16'h0C0C); expw(16'h7003, 16'h0D0D);
        expw(16'h7807, 16'h0E0E); expw(16'h8100, 16'h7777);
        expw(16'h7004, 16'h0007);
        compare_log("t5");
        chk("t5_count_after", {24'h0, loaded_count}, 32'd1);

        // ---- test 6: back-to-back descriptors, in_valid held high ----
        clear_all();
        send_hdr(16'h0008, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0000);
        send_hdr(16'h0009, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0000);
        wait_writes(12);
        for (int k = 0; k < 2; k++) begin
            expw(16'h7000, 16'h0101); expw(16'h7001, 16'h0202);
            expw(16'h7002, 16'h0303); expw(16'h7003, 16'h0404);
            expw(16'h7808 + 16'(k), 16'h0505); expw(16'h7004, 16'h0008 + 16'(k));
        end
        compare_log("t6");
        diff = (log_c.size() >= 7) ? (log_c[6] - log_c[5]) : -1;
        chk("t6_gap_to_next_hdr", diff, 32'd18);
        chk("t6_count", {24'h0, loaded_count}, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
